// File: rtl/fmul_pipe.sv
//============================================================================
// Module      : fmul_pipe
// Description : Three-stage pipelined floating-point multiplier with RNE
//               rounding, special-value handling and exception flags.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module fmul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [EXP_W+MAN_W:0]     a_i,
    input  logic [EXP_W+MAN_W:0]     b_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [EXP_W+MAN_W:0]     c_o,
    output logic [3:0]               flags_o
);

    localparam int c_w  = 1 + EXP_W + MAN_W;
    localparam int c_pw = 2 * MAN_W + 2;
    localparam int c_ew = EXP_W + 2;
    localparam logic [c_ew-1:0]  c_bias = c_ew'((1 << (EXP_W - 1)) - 1);
    localparam logic [c_ew-1:0]  c_emax = c_ew'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0] c_ones = '1;

    // Stage 1: unpack and classify
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic             w_nan, w_inf, w_zero;
    logic [c_ew-1:0]  w_e;

    assign w_ea     = a_i[c_w-2:MAN_W];
    assign w_eb     = b_i[c_w-2:MAN_W];
    assign w_fa     = a_i[MAN_W-1:0];
    assign w_fb     = b_i[MAN_W-1:0];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == c_ones) && (w_fa == '0);
    assign w_b_inf  = (w_eb == c_ones) && (w_fb == '0);
    assign w_a_nan  = (w_ea == c_ones) && (w_fa != '0);
    assign w_b_nan  = (w_eb == c_ones) && (w_fb != '0);
    assign w_nan    = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
    assign w_inf    = w_a_inf | w_b_inf;
    assign w_zero   = w_a_zero | w_b_zero;
    // Two guard bits keep the biased sum signed and free of wrap-around.
    assign w_e      = {2'b00, w_ea} + {2'b00, w_eb} - c_bias;

    logic             r1_valid, r1_sign, r1_nan, r1_inf, r1_zero;
    logic [c_ew-1:0]  r1_e;
    logic [MAN_W:0]   r1_ma, r1_mb;

    logic             r2_valid, r2_sign, r2_nan, r2_inf, r2_zero;
    logic [c_ew-1:0]  r2_e;
    logic [c_pw-1:0]  r2_p;

    logic [c_pw-1:0]  w_p;
    assign w_p = {{(MAN_W+1){1'b0}}, r1_ma} * {{(MAN_W+1){1'b0}}, r1_mb};

    // Stage 3: normalise, round to nearest even, select result
    logic             w_hi, w_g, w_s, w_rnd, w_inexact, w_ovf, w_unf;
    logic [MAN_W-1:0] w_m;
    logic [MAN_W:0]   w_msum;
    logic [c_ew-1:0]  w_e_fin;
    logic [c_w-1:0]   w_c;
    logic [3:0]       w_flags;

    always_comb begin
        w_hi = r2_p[c_pw-1];
        w_m  = '0;
        w_g  = 1'b0;
        w_s  = 1'b0;
        if (w_hi) begin
            w_m = r2_p[2*MAN_W:MAN_W+1];
            w_g = r2_p[MAN_W];
            w_s = |r2_p[MAN_W-1:0];
        end else begin
            w_m = r2_p[2*MAN_W-1:MAN_W];
            w_g = r2_p[MAN_W-1];
            w_s = |r2_p[MAN_W-2:0];
        end
        w_rnd     = w_g & (w_s | w_m[0]);
        w_msum    = {1'b0, w_m} + {{MAN_W{1'b0}}, w_rnd};
        w_e_fin   = r2_e + {{(c_ew-1){1'b0}}, w_hi} + {{(c_ew-1){1'b0}}, w_msum[MAN_W]};
        w_inexact = w_g | w_s;
        w_ovf     = $signed(w_e_fin) >= $signed(c_emax);
        w_unf     = w_e_fin[c_ew-1] | (w_e_fin == '0);

        w_c     = {r2_sign, w_e_fin[EXP_W-1:0], w_msum[MAN_W-1:0]};
        w_flags = {3'b000, w_inexact};
        if (r2_nan) begin
            w_c     = {1'b0, c_ones, 1'b1, {(MAN_W-1){1'b0}}};
            w_flags = 4'b1000;
        end else if (r2_inf) begin
            w_c     = {r2_sign, c_ones, {MAN_W{1'b0}}};
            w_flags = 4'b0000;
        end else if (r2_zero) begin
            w_c     = {r2_sign, {(EXP_W+MAN_W){1'b0}}};
            w_flags = 4'b0000;
        end else if (w_ovf) begin
            w_c     = {r2_sign, c_ones, {MAN_W{1'b0}}};
            w_flags = 4'b0101;
        end else if (w_unf) begin
            w_c     = {r2_sign, {(EXP_W+MAN_W){1'b0}}};
            w_flags = 4'b0011;
        end
    end

    logic w_stall;
    assign w_stall    = out_valid_o & ~out_ready_i;
    assign in_ready_o = ~w_stall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r1_valid    <= 1'b0;
            r1_sign     <= 1'b0;
            r1_nan      <= 1'b0;
            r1_inf      <= 1'b0;
            r1_zero     <= 1'b0;
            r1_e        <= '0;
            r1_ma       <= '0;
            r1_mb       <= '0;
            r2_valid    <= 1'b0;
            r2_sign     <= 1'b0;
            r2_nan      <= 1'b0;
            r2_inf      <= 1'b0;
            r2_zero     <= 1'b0;
            r2_e        <= '0;
            r2_p        <= '0;
            out_valid_o <= 1'b0;
            c_o         <= '0;
            flags_o     <= '0;
        end else if (!w_stall) begin
            r1_valid    <= in_valid_i;
            r1_sign     <= a_i[c_w-1] ^ b_i[c_w-1];
            r1_nan      <= w_nan;
            r1_inf      <= w_inf;
            r1_zero     <= w_zero;
            r1_e        <= w_e;
            r1_ma       <= {1'b1, w_fa};
            r1_mb       <= {1'b1, w_fb};
            r2_valid    <= r1_valid;
            r2_sign     <= r1_sign;
            r2_nan      <= r1_nan;
            r2_inf      <= r1_inf;
            r2_zero     <= r1_zero;
            r2_e        <= r1_e;
            r2_p        <= w_p;
            out_valid_o <= r2_valid;
            c_o         <= w_c;
            flags_o     <= w_flags;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fmul_pipe.sv
//============================================================================
// Module      : tb_fmul_pipe
// Description : Self-checking bench for fmul_pipe (FP32 and 16-bit configs).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_fmul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v32, ir32, ov32, or32;
    logic [31:0] a32, b32, c32;
    logic [3:0]  f32;
    logic        v16, ir16, ov16, or16;
    logic [15:0] a16, b16, c16;
    logic [3:0]  f16;

    fmul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v32), .in_ready_o(ir32),
        .a_i(a32), .b_i(b32), .out_valid_o(ov32), .out_ready_i(or32),
        .c_o(c32), .flags_o(f32));

    fmul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v16), .in_ready_o(ir16),
        .a_i(a16), .b_i(b16), .out_valid_o(ov16), .out_ready_i(or16),
        .c_o(c16), .flags_o(f16));

    int errors = 0;
    int checks = 0;
    int nout32 = 0;
    int nout16 = 0;
    logic [35:0] q32[$];
    logic [19:0] q16[$];
    logic        dir32_en, dir16_en;
    logic [35:0] dir32;
    logic [19:0] dir16;
    logic [31:0] hold;
    int          n0;

    logic [31:0] da [12] = '{32'h40400000, 32'h3FC00000, 32'h3FC00000, 32'h3F7FFFFF,
                             32'h7F000000, 32'h00800000, 32'hFF000000, 32'h7F800000,
                             32'h7F800001, 32'hFF800000, 32'h80000000, 32'h00000001};
    logic [31:0] db [12] = '{32'h40000000, 32'h3F800001, 32'h3F800003, 32'h3F7FFFFF,
                             32'h40000000, 32'h3F000000, 32'h40000000, 32'h00000000,
                             32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000};
    logic [31:0] dc [12] = '{32'h40C00000, 32'h3FC00002, 32'h3FC00004, 32'h3F7FFFFE,
                             32'h7F800000, 32'h00000000, 32'hFF800000, 32'h7FC00000,
                             32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000000};
    logic [3:0]  df [12] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0101, 4'b0011,
                             4'b0101, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};

    // Reference: exact integer product, then RNE on the discarded remainder.
    function automatic logic [67:0] model(input int ew, input int mw, input longint a, input longint b);
        longint one, emax, bias, sa, sb, ea, eb, fa, fb, s, p, q, r, half, e, c;
        int sh;
        logic [3:0] f;
        bit an, bn, ai, bi, az, bz;
        one  = 1;
        emax = (one << ew) - 1;
        bias = (one << (ew - 1)) - 1;
        sa = (a >> (ew + mw)) & 1;
        sb = (b >> (ew + mw)) & 1;
        ea = (a >> mw) & emax;
        eb = (b >> mw) & emax;
        fa = a & ((one << mw) - 1);
        fb = b & ((one << mw) - 1);
        s  = sa ^ sb;
        an = (ea == emax) && (fa != 0);
        bn = (eb == emax) && (fb != 0);
        ai = (ea == emax) && (fa == 0);
        bi = (eb == emax) && (fb == 0);
        az = (ea == 0);
        bz = (eb == 0);
        f  = 4'b0000;
        c  = 0;
        if (an || bn || (ai && bz) || (bi && az)) begin
            c = (emax << mw) | (one << (mw - 1));
            f = 4'b1000;
        end else if (ai || bi) begin
            c = (s << (ew + mw)) | (emax << mw);
        end else if (az || bz) begin
            c = s << (ew + mw);
        end else begin
            p  = (fa + (one << mw)) * (fb + (one << mw));
            e  = ea + eb - bias;
            sh = mw;
            if (p >= (one << (2 * mw + 1))) begin
                sh = mw + 1;
                e++;
            end
            q    = p >> sh;
            r    = p - (q << sh);
            half = one << (sh - 1);
            if (r > half || (r == half && q[0])) q++;
            if (q == (one << (mw + 1))) begin
                q = q >> 1;
                e++;
            end
            if (e >= emax) begin
                c = (s << (ew + mw)) | (emax << mw);
                f = 4'b0101;
            end else if (e <= 0) begin
                c = s << (ew + mw);
                f = 4'b0011;
            end else begin
                c = (s << (ew + mw)) | (e << mw) | (q - (one << mw));
                f = {3'b000, r != 0};
            end
        end
        return {c, f};
    endfunction

    function automatic logic [31:0] rnd32();
        logic [31:0] x;
        int k;
        x = $urandom;
        k = $urandom_range(0, 9);
        if (k == 0) x[30:23] = 8'd0;
        else if (k == 1) begin
            x[30:23] = 8'hFF;
            if ($urandom_range(0, 1) == 0) x[22:0] = '0;
        end else if (k >= 4) x[30:23] = 8'($urandom_range(110, 144));
        return x;
    endfunction

    function automatic logic [15:0] rnd16();
        logic [15:0] x;
        int k;
        x = 16'($urandom);
        k = $urandom_range(0, 9);
        if (k == 0) x[14:10] = 5'd0;
        else if (k == 1) begin
            x[14:10] = 5'h1F;
            if ($urandom_range(0, 1) == 0) x[9:0] = '0;
        end else if (k >= 4) x[14:10] = 5'($urandom_range(10, 20));
        return x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: record accepted operands and score consumed results at
    // the falling edge, then step past the rising edge.
    task automatic tick();
        logic [67:0] m;
        logic [35:0] e32;
        logic [19:0] e16;
        @(negedge clk);
        if (v32 && ir32) begin
            m = model(8, 23, longint'(a32), longint'(b32));
            q32.push_back(dir32_en ? dir32 : m[35:0]);
        end
        if (v16 && ir16) begin
            m = model(5, 10, longint'(a16), longint'(b16));
            q16.push_back(dir16_en ? dir16 : m[19:0]);
        end
        if (ov32 && or32) begin
            nout32++;
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL res32_extra observed=%h expected=none", c32);
            end else begin
                e32 = q32.pop_front();
                chk("res32", {28'd0, c32, f32}, {28'd0, e32});
            end
        end
        if (ov16 && or16) begin
            nout16++;
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL res16_extra observed=%h expected=none", c16);
            end else begin
                e16 = q16.pop_front();
                chk("res16", {44'd0, c16, f16}, {44'd0, e16});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        v32 = 1'b0; v16 = 1'b0; or32 = 1'b1; or16 = 1'b1;
        a32 = '0; b32 = '0; a16 = '0; b16 = '0;
        dir32_en = 1'b0; dir16_en = 1'b0; dir32 = '0; dir16 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid32", 64'(ov32), 64'd0);
        chk("rst_c32", 64'(c32), 64'd0);
        chk("rst_flags32", 64'(f32), 64'd0);
        chk("rst_valid16", 64'(ov16), 64'd0);
        rst_n = 1'b1;
        tick();

        // Latency: valid appears on the third edge after accept.
        dir32_en = 1'b1;
        v32 = 1'b1; a32 = 32'h40400000; b32 = 32'h40000000; dir32 = {32'h40C00000, 4'b0000};
        tick();
        v32 = 1'b0;
        chk("lat_edge1", 64'(ov32), 64'd0);
        tick();
        chk("lat_edge2", 64'(ov32), 64'd0);
        tick();
        chk("lat_edge3", 64'(ov32), 64'd1);
        tick();

        // Directed vectors issued back-to-back; results must be contiguous.
        for (int i = 0; i < 15; i++) begin
            if (i < 12) begin
                v32 = 1'b1; a32 = da[i]; b32 = db[i]; dir32 = {dc[i], df[i]};
            end else begin
                v32 = 1'b0;
            end
            tick();
            if (i >= 2 && i <= 13) chk("stream_valid", 64'(ov32), 64'd1);
            else if (i == 14) chk("stream_end", 64'(ov32), 64'd0);
        end
        dir32_en = 1'b0;

        // Reduced-precision configuration.
        dir16_en = 1'b1;
        v16 = 1'b1; a16 = 16'h3C00; b16 = 16'h4000; dir16 = {16'h4000, 4'b0000};
        tick();
        a16 = 16'h7BFF; b16 = 16'h4000; dir16 = {16'h7C00, 4'b0101};
        tick();
        v16 = 1'b0;
        repeat (4) tick();
        dir16_en = 1'b0;
        chk("fp16_count", 64'(nout16), 64'd2);

        // Backpressure with an extra operand waiting at the input.
        for (int i = 0; i < 4; i++) begin
            v32 = 1'b1; a32 = rnd32(); b32 = rnd32();
            tick();
        end
        n0 = nout32;
        a32 = rnd32(); b32 = rnd32();
        or32 = 1'b0;
        hold = c32;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_in_ready", 64'(ir32), 64'd0);
            chk("bp_out_valid", 64'(ov32), 64'd1);
            chk("bp_hold", 64'(c32), 64'(hold));
        end
        or32 = 1'b1;
        tick();
        v32 = 1'b0;
        for (int k = 0; k < 20 && q32.size() != 0; k++) tick();
        chk("bp_drain_count", 64'(nout32 - n0), 64'd4);

        // Asynchronous reset with operations in flight.
        v32 = 1'b1; a32 = rnd32(); b32 = rnd32();
        tick();
        a32 = rnd32(); b32 = rnd32();
        tick();
        v32 = 1'b0;
        tick();
        chk("rst_pre_valid", 64'(ov32), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(ov32), 64'd0);
        q32.delete();
        q16.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        n0 = nout32;
        repeat (6) tick();
        chk("rst_no_emit", 64'(nout32 - n0), 64'd0);

        // Randomised traffic with random backpressure on both configurations.
        for (int k = 0; k < 400; k++) begin
            v32 = ($urandom_range(0, 3) != 0); a32 = rnd32(); b32 = rnd32();
            or32 = ($urandom_range(0, 3) != 0);
            v16 = ($urandom_range(0, 3) != 0); a16 = rnd16(); b16 = rnd16();
            or16 = ($urandom_range(0, 3) != 0);
            tick();
        end
        v32 = 1'b0; v16 = 1'b0; or32 = 1'b1; or16 = 1'b1;
        for (int k = 0; k < 30 && (q32.size() != 0 || q16.size() != 0); k++) tick();
        chk("final_q32_empty", 64'(q32.size()), 64'd0);
        chk("final_q16_empty", 64'(q16.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
